// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - host-side bundle for the instruction memory loader
interface imem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int ERR_W  = 8
);
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic [1:0]        i_cmd;
  logic [ADDR_W-1:0] i_base;
  logic [ADDR_W:0]   i_len;
  logic              i_abort;
  logic              i_wd_valid;
  logic              o_wd_ready;
  logic [DATA_W-1:0] i_wd;
  logic              o_rd_valid;
  logic              i_rd_ready;
  logic [DATA_W-1:0] o_rd_data;
  logic [ADDR_W-1:0] o_exa;
  logic [DATA_W-1:0] o_exwd;
  logic              o_exwe;
  logic              o_exre;
  logic [DATA_W-1:0] i_mem_rd;
  logic              o_busy;
  logic              o_done;
  logic [ERR_W-1:0]  o_err_cnt;
  logic [ADDR_W-1:0] o_err_addr;

  modport slave (
    input  i_cmd_valid, i_cmd, i_base, i_len, i_abort, i_wd_valid, i_wd,
           i_rd_ready, i_mem_rd,
    output o_cmd_ready, o_wd_ready, o_rd_valid, o_rd_data, o_exa, o_exwd,
           o_exwe, o_exre, o_busy, o_done, o_err_cnt, o_err_addr
  );

  modport master (
    output i_cmd_valid, i_cmd, i_base, i_len, i_abort, i_wd_valid, i_wd,
           i_rd_ready, i_mem_rd,
    input  o_cmd_ready, o_wd_ready, o_rd_valid, o_rd_data, o_exa, o_exwd,
           o_exwe, o_exre, o_busy, o_done, o_err_cnt, o_err_addr
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - load / read back / verify controller for the instruction memory port
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int ERR_W  = 8
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_RDRAIN = 3'd3;
  localparam logic [2:0] S_VERIFY = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ERR_W-1:0]  ERR_ONE   = ERR_W'(1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W-1:0] r_exa;
  logic [DATA_W-1:0] r_exwd;
  logic              r_exwe;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic [ERR_W-1:0]  r_err_cnt;
  logic [ADDR_W-1:0] r_err_addr;

  logic              w_idle;
  logic              w_rd_path;
  logic              w_wd_ready;
  logic              w_wd_acc;
  logic              w_last;
  logic              w_rd_load;
  logic              w_mismatch;
  logic [ADDR_W-1:0] w_addr_nxt;

  assign w_idle     = (r_state == S_IDLE);
  // READ and VERIFY address the memory combinationally from the live pointer.
  assign w_rd_path  = (r_state == S_READ) || (r_state == S_VERIFY);
  assign w_wd_ready = (r_state == S_LOAD) || (r_state == S_VERIFY);
  assign w_wd_acc   = w_wd_ready && bus.i_wd_valid;
  assign w_last     = (r_cnt == CNT_ONE);
  assign w_rd_load  = (r_state == S_READ) && (!r_rd_valid || bus.i_rd_ready);
  assign w_mismatch = (bus.i_wd != bus.i_mem_rd);
  assign w_addr_nxt = (r_addr == LAST_ADDR) ? '0 : r_addr + ADDR_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_exa      <= '0;
      r_exwd     <= '0;
      r_exwe     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_err_cnt  <= '0;
      r_err_addr <= '0;
    end else begin
      r_exwe <= 1'b0;
      // Abort wins over everything, including a word accepted in the same cycle.
      if (!w_idle && bus.i_abort) begin
        r_state    <= S_IDLE;
        r_rd_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.i_cmd_valid && (bus.i_cmd != 2'b00)) begin
              r_addr <= bus.i_base;
              r_cnt  <= bus.i_len;
              if (bus.i_cmd == 2'b11) begin
                r_err_cnt  <= '0;
                r_err_addr <= '0;
              end
              if (bus.i_len == '0) begin
                r_state <= S_DONE;
              end else begin
                case (bus.i_cmd)
                  2'b01:   r_state <= S_LOAD;
                  2'b10:   r_state <= S_READ;
                  default: r_state <= S_VERIFY;
                endcase
              end
            end
          end
          S_LOAD: begin
            if (w_wd_acc) begin
              r_exa  <= r_addr;
              r_exwd <= bus.i_wd;
              r_exwe <= 1'b1;
              r_addr <= w_addr_nxt;
              r_cnt  <= r_cnt - CNT_ONE;
              if (w_last) r_state <= S_DONE;
            end
          end
          S_READ: begin
            if (w_rd_load) begin
              r_rd_data  <= bus.i_mem_rd;
              r_rd_valid <= 1'b1;
              r_addr     <= w_addr_nxt;
              r_cnt      <= r_cnt - CNT_ONE;
              if (w_last) r_state <= S_RDRAIN;
            end
          end
          S_RDRAIN: begin
            if (bus.i_rd_ready) begin
              r_rd_valid <= 1'b0;
              r_state    <= S_DONE;
            end
          end
          S_VERIFY: begin
            if (w_wd_acc) begin
              if (w_mismatch) begin
                if (!(&r_err_cnt)) r_err_cnt <= r_err_cnt + ERR_ONE;
                if (r_err_cnt == '0) r_err_addr <= r_addr;
              end
              r_addr <= w_addr_nxt;
              r_cnt  <= r_cnt - CNT_ONE;
              if (w_last) r_state <= S_DONE;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.o_cmd_ready = w_idle;
  assign bus.o_wd_ready  = w_wd_ready;
  assign bus.o_rd_valid  = r_rd_valid;
  assign bus.o_rd_data   = r_rd_data;
  assign bus.o_exa       = w_rd_path ? r_addr : r_exa;
  assign bus.o_exwd      = r_exwd;
  assign bus.o_exwe      = r_exwe;
  assign bus.o_exre      = w_rd_path;
  assign bus.o_busy      = !w_idle;
  assign bus.o_done      = (r_state == S_DONE);
  assign bus.o_err_cnt   = r_err_cnt;
  assign bus.o_err_addr  = r_err_addr;
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(8), .DATA_W(16), .ERR_W(8)) bus ();

  imem_loader #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .ERR_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [15:0] mem [256] = '{default: 16'h0000};
  assign bus.i_mem_rd = mem[bus.o_exa];
  always @(posedge clk) if (bus.o_exwe) mem[bus.o_exa] <= bus.o_exwd;

  int tests_run = 0;
  int failed = 0;
  int wr_count = 0;
  int done_count = 0;
  int exre_count = 0;
  int both_count = 0;
  logic [15:0] rd_buf [$];

  always @(negedge clk) begin
    if (bus.o_exwe) wr_count++;
    if (bus.o_done) done_count++;
    if (bus.o_exre) exre_count++;
    if (bus.o_exwe && bus.o_exre) both_count++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [1:0] cmd, input int base, input int len);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd = cmd;
    bus.i_base = 8'(base);
    bus.i_len = 9'(len);
    step();
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd = 2'b00;
  endtask

  task automatic push_word(input logic [15:0] w);
    bus.i_wd_valid = 1'b1;
    bus.i_wd = w;
    step();
    bus.i_wd_valid = 1'b0;
  endtask

  task automatic do_read(input int base, input int len, input int stall_at,
                         output bit stable_ok, output bit done_ok);
    int got = 0;
    int stalls = 0;
    int budget = 0;
    bit hs;
    logic [15:0] held = 16'h0;
    rd_buf.delete();
    stable_ok = 1'b1;
    done_ok = 1'b0;
    send_cmd(2'b10, base, len);
    while (got < len && budget < 200) begin
      bus.i_rd_ready = 1'b1;
      if (bus.o_rd_valid && got == stall_at && stalls < 2) begin
        if (stalls == 0) held = bus.o_rd_data;
        else if (bus.o_rd_data !== held) stable_ok = 1'b0;
        bus.i_rd_ready = 1'b0;
        stalls++;
      end else if (stalls > 0 && got == stall_at && bus.o_rd_data !== held) begin
        stable_ok = 1'b0;
      end
      hs = bus.o_rd_valid && bus.i_rd_ready;
      if (hs) begin
        rd_buf.push_back(bus.o_rd_data);
        got++;
      end
      step();
      budget++;
      if (hs && got == len) done_ok = (bus.o_done === 1'b1);
    end
    bus.i_rd_ready = 1'b0;
    step();
  endtask

  task automatic test_reset();
    tests_run++; if (bus.o_exwe !== 1'b0) begin failed++; $display("FAIL reset_exwe: got %b want 0", bus.o_exwe); end
    tests_run++; if (bus.o_exre !== 1'b0) begin failed++; $display("FAIL reset_exre: got %b want 0", bus.o_exre); end
    tests_run++; if (bus.o_rd_valid !== 1'b0) begin failed++; $display("FAIL reset_rd_valid: got %b want 0", bus.o_rd_valid); end
    tests_run++; if (bus.o_done !== 1'b0) begin failed++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
    tests_run++; if (bus.o_busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    tests_run++; if (bus.o_err_cnt !== 8'h00) begin failed++; $display("FAIL reset_err_cnt: got %h want 00", bus.o_err_cnt); end
    tests_run++; if (bus.o_err_addr !== 8'h00) begin failed++; $display("FAIL reset_err_addr: got %h want 00", bus.o_err_addr); end
  endtask

  task automatic test_load_basic();
    logic [15:0] words [4];
    logic [7:0] addrs [4];
    bit st, dn;
    words = '{16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4};
    addrs = '{8'h10, 8'h11, 8'h12, 8'h13};
    send_cmd(2'b01, 'h10, 4);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        step();
        tests_run++; if (bus.o_exwe !== 1'b0) begin failed++; $display("FAIL load_gap_we: got %b want 0", bus.o_exwe); end
      end
      push_word(words[i]);
      tests_run++; if (bus.o_exwe !== 1'b1 || bus.o_exa !== addrs[i] || bus.o_exwd !== words[i]) begin
        failed++; $display("FAIL load_write%0d: got we=%b a=%h d=%h want we=1 a=%h d=%h", i, bus.o_exwe, bus.o_exa, bus.o_exwd, addrs[i], words[i]);
      end
      tests_run++; if (bus.o_done !== (i == 3)) begin failed++; $display("FAIL load_done%0d: got %b want %b", i, bus.o_done, i == 3); end
    end
    step();
    tests_run++; if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin failed++; $display("FAIL load_idle: got busy=%b done=%b want 0 0", bus.o_busy, bus.o_done); end
    do_read('h10, 4, -1, st, dn);
    tests_run++; if (rd_buf.size() != 4) begin failed++; $display("FAIL load_readback_n: got %0d want 4", rd_buf.size()); end
    for (int i = 0; i < 4 && i < rd_buf.size(); i++) begin
      tests_run++; if (rd_buf[i] !== words[i]) begin failed++; $display("FAIL load_readback%0d: got %h want %h", i, rd_buf[i], words[i]); end
    end
    tests_run++; if (dn !== 1'b1) begin failed++; $display("FAIL load_read_done: got %b want 1", dn); end
  endtask

  task automatic test_wrap();
    logic [15:0] words [4];
    logic [7:0] addrs [4];
    bit st, dn;
    words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    addrs = '{8'd254, 8'd255, 8'd0, 8'd1};
    send_cmd(2'b01, 254, 4);
    for (int i = 0; i < 4; i++) begin
      push_word(words[i]);
      tests_run++; if (bus.o_exwe !== 1'b1 || bus.o_exa !== addrs[i]) begin
        failed++; $display("FAIL wrap_write%0d: got we=%b a=%0d want we=1 a=%0d", i, bus.o_exwe, bus.o_exa, addrs[i]);
      end
    end
    step();
    do_read(254, 4, -1, st, dn);
    tests_run++; if (rd_buf.size() != 4) begin failed++; $display("FAIL wrap_read_n: got %0d want 4", rd_buf.size()); end
    for (int i = 0; i < 4 && i < rd_buf.size(); i++) begin
      tests_run++; if (rd_buf[i] !== words[i]) begin failed++; $display("FAIL wrap_read%0d: got %h want %h", i, rd_buf[i], words[i]); end
    end
  endtask

  task automatic test_read_stall();
    logic [15:0] exp [3];
    bit st, dn;
    int d0;
    exp = '{16'h00A1, 16'h00B2, 16'h00C3};
    d0 = done_count;
    do_read('h10, 3, 1, st, dn);
    tests_run++; if (rd_buf.size() != 3) begin failed++; $display("FAIL stall_read_n: got %0d want 3", rd_buf.size()); end
    for (int i = 0; i < 3 && i < rd_buf.size(); i++) begin
      tests_run++; if (rd_buf[i] !== exp[i]) begin failed++; $display("FAIL stall_read%0d: got %h want %h", i, rd_buf[i], exp[i]); end
    end
    tests_run++; if (st !== 1'b1) begin failed++; $display("FAIL stall_stable: got %b want 1", st); end
    tests_run++; if (dn !== 1'b1) begin failed++; $display("FAIL stall_done_after: got %b want 1", dn); end
    tests_run++; if (done_count - d0 != 1) begin failed++; $display("FAIL stall_done_cnt: got %0d want 1", done_count - d0); end
  endtask

  task automatic test_verify();
    logic [15:0] bad [4];
    logic [15:0] good [4];
    int w0;
    bad  = '{16'h00A1, 16'h00FF, 16'h00C3, 16'h1234};
    good = '{16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4};
    w0 = wr_count;
    send_cmd(2'b11, 'h10, 4);
    for (int i = 0; i < 4; i++) push_word(bad[i]);
    tests_run++; if (bus.o_done !== 1'b1) begin failed++; $display("FAIL verify_done: got %b want 1", bus.o_done); end
    step();
    tests_run++; if (bus.o_err_cnt !== 8'd2) begin failed++; $display("FAIL verify_err_cnt: got %0d want 2", bus.o_err_cnt); end
    tests_run++; if (bus.o_err_addr !== 8'h11) begin failed++; $display("FAIL verify_err_addr: got %h want 11", bus.o_err_addr); end
    tests_run++; if (wr_count != w0) begin failed++; $display("FAIL verify_no_write: got %0d writes want 0", wr_count - w0); end
    send_cmd(2'b11, 'h10, 4);
    for (int i = 0; i < 4; i++) push_word(good[i]);
    step();
    tests_run++; if (bus.o_err_cnt !== 8'd0) begin failed++; $display("FAIL verify_clean_cnt: got %0d want 0", bus.o_err_cnt); end
    tests_run++; if (bus.o_err_addr !== 8'h00) begin failed++; $display("FAIL verify_clean_addr: got %h want 00", bus.o_err_addr); end
  endtask

  task automatic test_len0();
    int w0, r0, d0;
    w0 = wr_count; r0 = exre_count; d0 = done_count;
    send_cmd(2'b01, 5, 0);
    tests_run++; if (bus.o_done !== 1'b1) begin failed++; $display("FAIL len0_done: got %b want 1", bus.o_done); end
    step();
    tests_run++; if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin failed++; $display("FAIL len0_idle: got done=%b busy=%b want 0 0", bus.o_done, bus.o_busy); end
    tests_run++; if (done_count - d0 != 1) begin failed++; $display("FAIL len0_done_cnt: got %0d want 1", done_count - d0); end
    tests_run++; if (wr_count != w0 || exre_count != r0) begin failed++; $display("FAIL len0_no_access: got wr=%0d re=%0d want 0 0", wr_count - w0, exre_count - r0); end
  endtask

  task automatic test_abort();
    int w0, d0;
    w0 = wr_count; d0 = done_count;
    send_cmd(2'b01, 'h40, 8);
    push_word(16'h5001);
    push_word(16'h5002);
    push_word(16'h5003);
    bus.i_abort = 1'b1;
    bus.i_wd_valid = 1'b1;
    bus.i_wd = 16'h5004;
    step();
    bus.i_abort = 1'b0;
    bus.i_wd_valid = 1'b0;
    tests_run++; if (bus.o_busy !== 1'b0 || bus.o_exwe !== 1'b0 || bus.o_done !== 1'b0) begin
      failed++; $display("FAIL abort_state: got busy=%b we=%b done=%b want 0 0 0", bus.o_busy, bus.o_exwe, bus.o_done);
    end
    step(); step();
    tests_run++; if (wr_count - w0 != 3) begin failed++; $display("FAIL abort_writes: got %0d want 3", wr_count - w0); end
    tests_run++; if (done_count != d0) begin failed++; $display("FAIL abort_no_done: got %0d want 0", done_count - d0); end
    tests_run++; if (mem[8'h42] !== 16'h5003 || mem[8'h43] !== 16'h0000) begin
      failed++; $display("FAIL abort_mem: got %h %h want 5003 0000", mem[8'h42], mem[8'h43]);
    end
  endtask

  task automatic test_reset_mid();
    int w0, d0;
    send_cmd(2'b11, 'h40, 1);
    push_word(16'hFFFF);
    step();
    tests_run++; if (bus.o_err_cnt !== 8'd1 || bus.o_err_addr !== 8'h40) begin
      failed++; $display("FAIL rst_pre_err: got cnt=%0d addr=%h want 1 40", bus.o_err_cnt, bus.o_err_addr);
    end
    w0 = wr_count; d0 = done_count;
    send_cmd(2'b01, 'h60, 8);
    push_word(16'h6001);
    push_word(16'h6002);
    push_word(16'h6003);
    bus.i_wd_valid = 1'b1;
    bus.i_wd = 16'h6004;
    rst_n = 1'b0;
    #1;
    tests_run++; if (bus.o_exwe !== 1'b0 || bus.o_exre !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_rd_valid !== 1'b0) begin
      failed++; $display("FAIL rst_mid_ctrl: got we=%b re=%b busy=%b done=%b rv=%b want all 0", bus.o_exwe, bus.o_exre, bus.o_busy, bus.o_done, bus.o_rd_valid);
    end
    tests_run++; if (bus.o_err_cnt !== 8'd0 || bus.o_err_addr !== 8'h00) begin
      failed++; $display("FAIL rst_mid_err: got cnt=%0d addr=%h want 0 00", bus.o_err_cnt, bus.o_err_addr);
    end
    step(); step();
    rst_n = 1'b1;
    bus.i_wd_valid = 1'b0;
    step(); step();
    tests_run++; if (wr_count - w0 > 3) begin failed++; $display("FAIL rst_mid_writes: got %0d want <=3", wr_count - w0); end
    tests_run++; if (done_count != d0 || bus.o_busy !== 1'b0) begin failed++; $display("FAIL rst_mid_idle: got done=%0d busy=%b want 0 0", done_count - d0, bus.o_busy); end
    tests_run++; if (mem[8'h61] !== 16'h6002 || mem[8'h63] !== 16'h0000) begin
      failed++; $display("FAIL rst_mid_mem: got %h %h want 6002 0000", mem[8'h61], mem[8'h63]);
    end
  endtask

  initial begin
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd = 2'b00;
    bus.i_base = 8'h00;
    bus.i_len = 9'h000;
    bus.i_abort = 1'b0;
    bus.i_wd_valid = 1'b0;
    bus.i_wd = 16'h0000;
    bus.i_rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    step();
    test_load_basic();
    test_wrap();
    test_read_stall();
    test_verify();
    test_len0();
    test_abort();
    test_reset_mid();
    tests_run++; if (both_count != 0) begin failed++; $display("FAIL we_re_overlap: got %0d cycles want 0", both_count); end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Host-side controller that drives the instruction memory's external access port (external address, write data, write enable, read enable).
- It loads program words from a valid/ready stream, reads memory back to a stream, and verifies memory against a stream with an error count.
- It sits between the chip's host/debug interface and the instruction memory.
- o_busy holds the core off while an operation runs.

Parameters:
- ADDR_W, 8, external address width; top level overrides with the instruction-address width.
- DATA_W, 16, word width; top level overrides with the CPU word width.
- DEPTH, 256, number of memory words; all addresses wrap modulo DEPTH.
- ERR_W, 8, width of the verify error counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_cmd_valid  in  1  command strobe.
- o_cmd_ready  out  1  command accepted; high only in IDLE.
- i_cmd  in  2  command: 00 NOP, 01 LOAD, 10 READ, 11 VERIFY.
- i_base  in  ADDR_W  start address.
- i_len  in  ADDR_W+1  word count, 0..DEPTH.
- i_abort  in  1  terminates the current operation.
- i_wd_valid  in  1  input word valid.
- o_wd_ready  out  1  input word ready.
- i_wd  in  DATA_W  input word.
- o_rd_valid  out  1  readback word valid.
- i_rd_ready  in  1  readback word consumed.
- o_rd_data  out  DATA_W  readback word.
- o_exa  out  ADDR_W  memory external address.
- o_exwd  out  DATA_W  memory write data.
- o_exwe  out  1  memory write enable.
- o_exre  out  1  memory read enable (selects o_exa for the read path).
- i_mem_rd  in  DATA_W  memory combinational read data.
- o_busy  out  1  high when state is not IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_err_cnt  out  ERR_W  verify mismatch count, saturating.
- o_err_addr  out  ADDR_W  address of the first verify mismatch.

Behaviour:
- Reset: the reset decision above is fixed: one clock; reset is asynchronous and active-low.
  - Asserting rst_n low forces IDLE and zeroes every output and counter, including o_exwe, o_exre, o_rd_valid, o_done, o_err_cnt and o_err_addr.
  - Reset mid-operation leaves already-written words in place; no partial write is issued after reset.
- States: IDLE, LOAD, READ, RDRAIN, VERIFY, DONE.
- IDLE:
  - A command is accepted when i_cmd_valid is high (o_cmd_ready is high in IDLE).
  - On acceptance, the address register loads i_base and the remaining-count register loads i_len.
  - NOP: stays in IDLE and produces no o_done.
  - len=0 with any non-NOP command: goes directly to DONE.
  - VERIFY clears o_err_cnt and o_err_addr on acceptance.
- LOAD:
  - o_wd_ready=1 throughout.
  - On each accepted word: o_exa<=addr, o_exwd<=i_wd, o_exwe<=1 for exactly the following cycle; then addr+1 (wrapping) and count-1.
  - Throughput is one word per cycle; gaps in i_wd_valid produce o_exwe=0 cycles.
  - The last accepted word moves the state to DONE; its o_exwe cycle coincides with the o_done cycle.
- READ:
  - o_exre=1 and o_exa=addr.
  - The output register loads i_mem_rd when o_rd_valid is 0 or i_rd_ready is 1; each load advances addr and count.
  - o_rd_data and o_rd_valid hold stable while o_rd_valid=1 and i_rd_ready=0.
  - The last load moves the state to RDRAIN.
- RDRAIN: o_exre=0; waits until the final word is consumed (i_rd_ready=1), then goes to DONE.
- VERIFY:
  - o_exre=1, o_exa=addr, o_wd_ready=1.
  - On each accepted word, i_wd is compared with i_mem_rd in the same cycle.
  - On a mismatch, o_err_cnt increments (holding at 2^ERR_W-1). On the first mismatch only, o_err_addr<=addr.
  - After the last word, the state goes to DONE.
  - No writes are issued in VERIFY.
- DONE: o_done=1 for one cycle, then IDLE; o_err_cnt and o_err_addr hold until the next VERIFY.
- i_abort:
  - In any non-IDLE state, the next state is IDLE with no o_done.
  - o_exre and o_rd_valid drop the next cycle.
  - A write registered from a word accepted in the abort cycle is suppressed.
  - i_abort has priority over all other events.
- o_wd_ready=0 and o_exwe=0 outside LOAD and VERIFY (o_exwe only in the cycle after a LOAD accept).
- o_exwe and o_exre are never high in the same cycle.
- Address wrap: DEPTH-1 +1 -> 0.
- len=DEPTH processes every address exactly once.

Test Plan:
- LOAD base=0x10, len=4, words A1,B2,C3,D4 with one idle cycle between B2 and C3 -> o_exwe pulses at addresses 0x10..0x13 one cycle after each accept, a gap cycle appears, and o_done pulses with the 0x13 write; a following READ returns A1,B2,C3,D4.
- LOAD base=DEPTH-2, len=4 -> writes land at 254, 255, 0, 1; READ base=254, len=4 matches.
- READ len=3 with i_rd_ready low for 2 cycles on the second word -> o_rd_data holds stable, no word is lost or duplicated, and o_done follows the final handshake.
- VERIFY of 4 words where the words at the 2nd and 4th positions differ -> o_err_cnt=2 and o_err_addr is the 2nd address; no o_exwe is seen; a clean VERIFY afterwards gives o_err_cnt=0.
- Command with len=0 -> DONE next cycle, o_done for 1 cycle, no memory access.
- LOAD len=8, with i_abort asserted after 3 accepts in one run and rst_n pulsed low after 3 accepts in a second run -> IDLE, no o_done, at most 3 writes, and outputs zero during reset.
